// File: rtl/dkong_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dkong_pkg                                                          |
// | Shared types and constants for the dkong work-RAM arbiter.         |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package dkong_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } arb_state_t;

    localparam logic OWNER_CPU  = 1'b0;
    localparam logic OWNER_HOST = 1'b1;

endpackage
`default_nettype wire

// File: rtl/dkong_rr_arb2.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dkong_rr_arb2                                                      |
// | Combinational two-way round-robin pick with per-requester mask.    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module dkong_rr_arb2
    import dkong_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_owner,
    input  logic [1:0] mask,
    output logic       gnt_valid,
    output logic       gnt_owner
);

    logic [1:0] w_eff;

    always_comb begin
        w_eff     = req & ~mask;
        gnt_valid = |w_eff;
        gnt_owner = OWNER_CPU;
        // On a tie the port that did not win last time goes first.
        if (w_eff == 2'b11) begin
            gnt_owner = ~last_owner;
        end else if (w_eff[OWNER_HOST]) begin
            gnt_owner = OWNER_HOST;
        end
    end

endmodule
`default_nettype wire

// File: rtl/dkong_mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dkong_mem_arbiter                                                  |
// | Shares the work RAM between the Z80 bus and the host loader port.  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module dkong_mem_arbiter
    import dkong_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
) (
    input  logic              masterclk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_ack,
    output logic [DATA_W-1:0] host_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_t        r_state;
    arb_state_t        w_state_nxt;
    logic              r_owner;
    logic              r_last_owner;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_mem_en;
    logic              r_mem_we;
    logic              r_cpu_ack;
    logic              r_host_ack;
    logic [DATA_W-1:0] r_cpu_hold;
    logic [DATA_W-1:0] r_host_hold;

    logic [1:0]        w_mask;
    logic              w_gnt_valid;
    logic              w_gnt_owner;
    logic              w_grant;
    logic              w_sel_we;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;

    // The owner being answered in RESP may not be re-granted in the same cycle.
    assign w_mask = (r_state == RESP) ? (2'b01 << r_owner) : 2'b00;

    dkong_rr_arb2 u_rr_arb2 (
        .req        ({host_req, cpu_req}),
        .last_owner (r_last_owner),
        .mask       (w_mask),
        .gnt_valid  (w_gnt_valid),
        .gnt_owner  (w_gnt_owner)
    );

    assign w_sel_we    = (w_gnt_owner == OWNER_HOST) ? host_we    : cpu_we;
    assign w_sel_addr  = (w_gnt_owner == OWNER_HOST) ? host_addr  : cpu_addr;
    assign w_sel_wdata = (w_gnt_owner == OWNER_HOST) ? host_wdata : cpu_wdata;

    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        case (r_state)
            IDLE: begin
                if (!freeze && w_gnt_valid) begin
                    w_grant     = 1'b1;
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                w_state_nxt = RESP;
            end
            RESP: begin
                if (!freeze && w_gnt_valid) begin
                    w_grant     = 1'b1;
                    w_state_nxt = ISSUE;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge masterclk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_owner      <= OWNER_CPU;
            r_last_owner <= OWNER_HOST;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_mem_en     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_cpu_ack    <= 1'b0;
            r_host_ack   <= 1'b0;
            r_cpu_hold   <= '0;
            r_host_hold  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_mem_en   <= w_grant;
            r_mem_we   <= w_grant & w_sel_we;
            r_cpu_ack  <= (r_state == ISSUE) && (r_owner == OWNER_CPU);
            r_host_ack <= (r_state == ISSUE) && (r_owner == OWNER_HOST);
            if (w_grant) begin
                r_owner      <= w_gnt_owner;
                r_last_owner <= w_gnt_owner;
                r_we         <= w_sel_we;
                r_addr       <= w_sel_addr;
                r_wdata      <= w_sel_wdata;
            end
            // r_we/r_owner still describe the access being answered here.
            if (r_state == RESP && !r_we) begin
                if (r_owner == OWNER_HOST) begin
                    r_host_hold <= mem_rdata;
                end else begin
                    r_cpu_hold <= mem_rdata;
                end
            end
        end
    end

    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign cpu_ack   = r_cpu_ack;
    assign host_ack  = r_host_ack;

    assign cpu_rdata  = (r_state == RESP && r_owner == OWNER_CPU)  ? mem_rdata : r_cpu_hold;
    assign host_rdata = (r_state == RESP && r_owner == OWNER_HOST) ? mem_rdata : r_host_hold;

endmodule
`default_nettype wire

// File: tb/tb_dkong_mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_dkong_mem_arbiter                                               |
// | Directed scenarios plus randomized traffic against an event model. |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_dkong_mem_arbiter;

    logic        masterclk = 1'b0;
    logic        rst       = 1'b0;
    logic        freeze    = 1'b0;
    logic        cpu_req   = 1'b0;
    logic        cpu_we    = 1'b0;
    logic [15:0] cpu_addr  = '0;
    logic [7:0]  cpu_wdata = '0;
    logic        cpu_ack;
    logic [7:0]  cpu_rdata;
    logic        host_req   = 1'b0;
    logic        host_we    = 1'b0;
    logic [15:0] host_addr  = '0;
    logic [7:0]  host_wdata = '0;
    logic        host_ack;
    logic [7:0]  host_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = '0;

    logic [7:0]  ram [0:65535];
    logic [7:0]  shadow [bit [15:0]];
    int          tests = 0;
    int          fails = 0;

    dkong_mem_arbiter #(.ADDR_W(16), .DATA_W(8)) dut (
        .masterclk  (masterclk),
        .rst        (rst),
        .freeze     (freeze),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_ack    (cpu_ack),
        .cpu_rdata  (cpu_rdata),
        .host_req   (host_req),
        .host_we    (host_we),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .host_ack   (host_ack),
        .host_rdata (host_rdata),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always #5 masterclk = ~masterclk;

    // Single-port RAM: read data appears the cycle after the strobe.
    always @(posedge masterclk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    task automatic tick();
        @(posedge masterclk);
        #1;
    endtask

    task automatic apply_reset();
        cpu_req = 1'b0; host_req = 1'b0; freeze = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tests++;
        if ({mem_en, mem_we, mem_addr, mem_wdata} !== 26'd0) begin
            fails++;
            $display("FAIL reset_mem: got %h expected 0", {mem_en, mem_we, mem_addr, mem_wdata});
        end
        tests++;
        if ({cpu_ack, host_ack, cpu_rdata, host_rdata} !== 18'd0) begin
            fails++;
            $display("FAIL reset_ports: got %h expected 0", {cpu_ack, host_ack, cpu_rdata, host_rdata});
        end
        rst = 1'b0;
    endtask

    task automatic test_cpu_read();
        apply_reset();
        ram[16'h1234] = 8'hA5;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h1234;
        tick();
        tests++;
        if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 16'h1234}) begin
            fails++;
            $display("FAIL cpu_read_issue: got %h expected %h", {mem_en, mem_we, mem_addr}, {1'b1, 1'b0, 16'h1234});
        end
        tick();
        tests++;
        if ({cpu_ack, host_ack, cpu_rdata, host_rdata} !== {1'b1, 1'b0, 8'hA5, 8'h00}) begin
            fails++;
            $display("FAIL cpu_read_resp: got %h expected %h", {cpu_ack, host_ack, cpu_rdata, host_rdata}, {1'b1, 1'b0, 8'hA5, 8'h00});
        end
        cpu_req = 1'b0;
        tick();
        tests++;
        if ({cpu_ack, mem_en, cpu_rdata} !== {1'b0, 1'b0, 8'hA5}) begin
            fails++;
            $display("FAIL cpu_read_hold: got %h expected %h", {cpu_ack, mem_en, cpu_rdata}, {1'b0, 1'b0, 8'hA5});
        end
    endtask

    task automatic test_tie_alternation();
        logic       e_en, e_cack, e_hack;
        logic [15:0] e_addr;
        apply_reset();
        cpu_req  = 1'b1; cpu_we  = 1'b0; cpu_addr  = 16'h0100;
        host_req = 1'b1; host_we = 1'b0; host_addr = 16'h0200;
        for (int k = 1; k <= 8; k++) begin
            tick();
            e_en   = (k % 2) == 1;
            e_addr = ((k % 4) == 1) ? 16'h0100 : 16'h0200;
            e_cack = (k % 4) == 2;
            e_hack = (k % 4) == 0;
            tests++;
            if ({mem_en, cpu_ack, host_ack} !== {e_en, e_cack, e_hack}) begin
                fails++;
                $display("FAIL tie_seq k=%0d: got en/cack/hack %b expected %b", k, {mem_en, cpu_ack, host_ack}, {e_en, e_cack, e_hack});
            end
            if (e_en) begin
                tests++;
                if (mem_addr !== e_addr) begin
                    fails++;
                    $display("FAIL tie_addr k=%0d: got %h expected %h", k, mem_addr, e_addr);
                end
            end
        end
        cpu_req = 1'b0; host_req = 1'b0;
        tick();
    endtask

    task automatic test_write_then_read();
        apply_reset();
        host_req = 1'b1; host_we = 1'b1; host_addr = 16'h0010; host_wdata = 8'h3C;
        tick();
        tick();
        tests++;
        if ({host_ack, cpu_ack} !== 2'b10) begin
            fails++;
            $display("FAIL wr_ack: got %b expected 10", {host_ack, cpu_ack});
        end
        host_req = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
        tick();
        tests++;
        if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 16'h0010}) begin
            fails++;
            $display("FAIL rd_issue: got %h expected %h", {mem_en, mem_we, mem_addr}, {1'b1, 1'b0, 16'h0010});
        end
        tick();
        tests++;
        if ({cpu_ack, cpu_rdata, host_rdata, ram[16'h0010]} !== {1'b1, 8'h3C, 8'h00, 8'h3C}) begin
            fails++;
            $display("FAIL rd_data: got %h expected %h", {cpu_ack, cpu_rdata, host_rdata, ram[16'h0010]}, {1'b1, 8'h3C, 8'h00, 8'h3C});
        end
        cpu_req = 1'b0;
        tick();
    endtask

    task automatic test_freeze();
        apply_reset();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0300;
        tick();
        freeze = 1'b1;
        host_req = 1'b1; host_we = 1'b0; host_addr = 16'h0400;
        tick();
        tests++;
        if (cpu_ack !== 1'b1) begin
            fails++;
            $display("FAIL freeze_inflight_ack: got %b expected 1", cpu_ack);
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            tests++;
            if ({mem_en, cpu_ack, host_ack} !== 3'b000) begin
                fails++;
                $display("FAIL freeze_block k=%0d: got %b expected 000", k, {mem_en, cpu_ack, host_ack});
            end
        end
        freeze = 1'b0;
        tick();
        tests++;
        if ({mem_en, mem_addr} !== {1'b1, 16'h0400}) begin
            fails++;
            $display("FAIL freeze_resume: got %h expected %h", {mem_en, mem_addr}, {1'b1, 16'h0400});
        end
        cpu_req = 1'b0; host_req = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset_mid_access();
        apply_reset();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0500;
        tick();
        #2 rst = 1'b1;
        #1;
        tests++;
        if ({mem_en, mem_we, mem_addr, mem_wdata, cpu_ack, host_ack} !== 28'd0) begin
            fails++;
            $display("FAIL rst_mid_outputs: got %h expected 0", {mem_en, mem_we, mem_addr, mem_wdata, cpu_ack, host_ack});
        end
        tick();
        rst = 1'b0;
        tests++;
        if ({cpu_ack, mem_en} !== 2'b00) begin
            fails++;
            $display("FAIL rst_mid_noack: got %b expected 00", {cpu_ack, mem_en});
        end
        host_req = 1'b1; host_we = 1'b0; host_addr = 16'h0600;
        tick();
        tests++;
        if ({mem_en, mem_addr} !== {1'b1, 16'h0500}) begin
            fails++;
            $display("FAIL rst_mid_cpu_first: got %h expected %h", {mem_en, mem_addr}, {1'b1, 16'h0500});
        end
        tick();
        cpu_req = 1'b0; host_req = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        int pulses;
        pulses = 0;
        apply_reset();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0700;
        for (int k = 1; k <= 9; k++) begin
            tick();
            if (mem_en === 1'b1) pulses++;
            tests++;
            if ({mem_en, cpu_ack} !== {((k % 3) == 1), ((k % 3) == 2)}) begin
                fails++;
                $display("FAIL b2b k=%0d: got en/ack %b expected %b", k, {mem_en, cpu_ack}, {((k % 3) == 1), ((k % 3) == 2)});
            end
        end
        cpu_req = 1'b0;
        tests++;
        if (pulses != 3) begin
            fails++;
            $display("FAIL b2b_pulses: got %0d expected 3", pulses);
        end
        tick();
    endtask

    // Event-schedule model: a grant decided in cycle c yields a strobe in
    // c+1 and an ack in c+2; the arbiter is busy only during the strobe
    // cycle and refuses the answered owner in the ack cycle.
    task automatic test_random(input int ncyc, input int freeze_pct);
        bit          rq [2];
        bit          rwe [2];
        logic [15:0] raddr [2];
        logic [7:0]  rwd [2];
        logic [7:0]  hold [2];
        int          iss_at, resp_at;
        bit          resp_o, iss_we, resp_we, last;
        logic [15:0] iss_a;
        logic [7:0]  iss_d, resp_d;
        logic [1:0]  r;
        bit          o, e_ack;
        logic [7:0]  got;

        apply_reset();
        for (int i = 0; i < 16; i++) begin
            ram[16'h8000 + 16'(i)]    = 8'($urandom);
            shadow[16'h8000 + 16'(i)] = ram[16'h8000 + 16'(i)];
        end
        for (int p = 0; p < 2; p++) begin
            rq[p] = 0; rwe[p] = 0; raddr[p] = '0; rwd[p] = '0; hold[p] = '0;
        end
        iss_at = -1; resp_at = -1; resp_o = 0; last = 1;
        iss_we = 0; resp_we = 0; iss_a = '0; iss_d = '0; resp_d = '0;

        for (int c = 0; c < ncyc; c++) begin
            for (int p = 0; p < 2; p++) begin
                if (rq[p] && resp_at == c && resp_o == p[0]) begin
                    rq[p] = ($urandom_range(1, 0) == 1);
                    rwe[p] = ($urandom_range(1, 0) == 1);
                    raddr[p] = 16'h8000 | 16'($urandom_range(15, 0));
                    rwd[p] = 8'($urandom);
                end else if (!rq[p] && $urandom_range(2, 0) == 0) begin
                    rq[p] = 1;
                    rwe[p] = ($urandom_range(1, 0) == 1);
                    raddr[p] = 16'h8000 | 16'($urandom_range(15, 0));
                    rwd[p] = 8'($urandom);
                end
            end
            cpu_req = rq[0];  cpu_we = rwe[0];  cpu_addr = raddr[0];  cpu_wdata = rwd[0];
            host_req = rq[1]; host_we = rwe[1]; host_addr = raddr[1]; host_wdata = rwd[1];
            freeze = ($urandom_range(99, 0) < freeze_pct);

            @(negedge masterclk);
            tests++;
            if (mem_en !== (iss_at == c)) begin
                fails++;
                $display("FAIL rnd_en c=%0d: got %b expected %b", c, mem_en, (iss_at == c));
            end
            if (iss_at == c) begin
                tests++;
                if ({mem_we, mem_addr} !== {iss_we, iss_a} || (iss_we && mem_wdata !== iss_d)) begin
                    fails++;
                    $display("FAIL rnd_issue c=%0d: got %h expected %h", c, {mem_we, mem_addr, mem_wdata}, {iss_we, iss_a, iss_d});
                end
            end
            for (int p = 0; p < 2; p++) begin
                e_ack = (resp_at == c) && (resp_o == p[0]);
                got = (p == 0) ? cpu_rdata : host_rdata;
                tests++;
                if (((p == 0) ? cpu_ack : host_ack) !== e_ack) begin
                    fails++;
                    $display("FAIL rnd_ack p=%0d c=%0d: got %b expected %b", p, c, ((p == 0) ? cpu_ack : host_ack), e_ack);
                end
                if (e_ack && !resp_we) begin
                    tests++;
                    if (got !== resp_d) begin
                        fails++;
                        $display("FAIL rnd_rdata p=%0d c=%0d: got %h expected %h", p, c, got, resp_d);
                    end
                end else if (!e_ack) begin
                    tests++;
                    if (got !== hold[p]) begin
                        fails++;
                        $display("FAIL rnd_hold p=%0d c=%0d: got %h expected %h", p, c, got, hold[p]);
                    end
                end
            end
            if (resp_at == c && !resp_we) hold[resp_o] = resp_d;

            r = {rq[1], rq[0]};
            if (resp_at == c) r[resp_o] = 1'b0;
            if (iss_at != c && !freeze && r != 2'b00) begin
                o = (r == 2'b11) ? ~last : r[1];
                last = o;
                iss_at = c + 1; resp_at = c + 2; resp_o = o;
                iss_we = rwe[o]; iss_a = raddr[o]; iss_d = rwd[o];
                resp_we = rwe[o];
                if (rwe[o]) shadow[raddr[o]] = rwd[o];
                else        resp_d = shadow[raddr[o]];
            end
            tick();
        end
        cpu_req = 1'b0; host_req = 1'b0; freeze = 1'b0;
        repeat (3) tick();
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
        test_reset();
        test_cpu_read();
        test_tie_alternation();
        test_write_then_read();
        test_freeze();
        test_reset_mid_access();
        test_back_to_back();
        test_random(2000, 0);
        test_random(2000, 25);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
